// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared constants for the alu issue stage.
//  - ALU op encodings (forwarded untouched; the alu owns their meaning)
//  - FSM state encodings for the issue sequencer
//  - default operand width and register count
package alu_issue_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_N  = 32;
  localparam int DEF_IMM_W  = 16;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

endpackage

// File: rtl/issue_grf.sv
// issue_grf: REG_N x DATA_W register file.
//  Ports: clk/rst_n (async active-low clear of every entry),
//   we_i/waddr_i/wdata_i  synchronous write port,
//   ra0_i->rd0_o, ra1_i->rd1_o, ra2_i->rd2_o  asynchronous read ports.
//  Entry 0 is never written and always reads as zero.
module issue_grf #(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we_i,
  input  logic [$clog2(REG_N)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [$clog2(REG_N)-1:0] ra0_i,
  output logic [DATA_W-1:0]        rd0_o,
  input  logic [$clog2(REG_N)-1:0] ra1_i,
  output logic [DATA_W-1:0]        rd1_o,
  input  logic [$clog2(REG_N)-1:0] ra2_i,
  output logic [DATA_W-1:0]        rd2_o
);

  localparam int AW = $clog2(REG_N);

  logic [DATA_W-1:0] mem_q [REG_N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_N; i++) mem_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Address 0 is forced to zero on the read side as well, so the hard-wired
  // zero holds even if the storage for entry 0 is trimmed away.
  assign rd0_o = (ra0_i == AW'(0)) ? '0 : mem_q[ra0_i];
  assign rd1_o = (ra1_i == AW'(0)) ? '0 : mem_q[ra1_i];
  assign rd2_o = (ra2_i == AW'(0)) ? '0 : mem_q[ra2_i];

endmodule

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: operand fetch / write-back sequencer for an external
// combinational alu. One command in flight: IDLE -> EXEC -> WB -> IDLE.
//  cmd_*   : valid/ready command port (ready only in IDLE)
//  alu_*   : registered operands/op to the alu, alu_c result back
//  wb_*    : one-cycle registered write-back report (also for rd==0)
//  dbg_*   : asynchronous register file peek, rf[0] reads 0
module alu_issue_unit
  import alu_issue_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_N  = DEF_REG_N,
  parameter int IMM_W  = DEF_IMM_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_op,
  input  logic [$clog2(REG_N)-1:0] cmd_rs,
  input  logic [$clog2(REG_N)-1:0] cmd_rt,
  input  logic [$clog2(REG_N)-1:0] cmd_rd,
  input  logic                     cmd_imm_en,
  input  logic [IMM_W-1:0]         cmd_imm,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  output logic [2:0]               alu_op,
  input  logic [DATA_W-1:0]        alu_c,
  output logic                     wb_valid,
  output logic [$clog2(REG_N)-1:0] wb_rd,
  output logic [DATA_W-1:0]        wb_data,
  input  logic [$clog2(REG_N)-1:0] dbg_addr,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int AW = $clog2(REG_N);

  logic [1:0]        state_q, state_d;
  logic              accept;
  logic [DATA_W-1:0] rs_data, rt_data, b_sel;
  logic [DATA_W-1:0] alu_a_q, alu_b_q, res_q;
  logic [2:0]        alu_op_q;
  logic [AW-1:0]     rd_q;
  logic              wb_valid_q;
  logic [AW-1:0]     wb_rd_q;
  logic [DATA_W-1:0] wb_data_q;

  assign cmd_ready = (state_q == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign b_sel     = cmd_imm_en ? {{(DATA_W-IMM_W){1'b0}}, cmd_imm} : rt_data;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cmd_valid) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      rd_q       <= '0;
      res_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q <= state_d;
      // Operands only move on accept so the alu inputs stay quiet in IDLE.
      if (accept) begin
        alu_a_q  <= rs_data;
        alu_b_q  <= b_sel;
        alu_op_q <= cmd_op;
        rd_q     <= cmd_rd;
      end
      if (state_q == ST_EXEC) res_q <= alu_c;
      wb_valid_q <= (state_q == ST_WB);
      if (state_q == ST_WB) begin
        wb_rd_q   <= rd_q;
        wb_data_q <= res_q;
      end
    end
  end

  // The rf ignores writes to entry 0, so the WB write needs no rd check here.
  issue_grf #(.DATA_W(DATA_W), .REG_N(REG_N)) u_grf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (state_q == ST_WB),
    .waddr_i (rd_q),
    .wdata_i (res_q),
    .ra0_i   (cmd_rs),
    .rd0_o   (rs_data),
    .ra1_i   (cmd_rt),
    .rd1_o   (rt_data),
    .ra2_i   (dbg_addr),
    .rd2_o   (dbg_data)
  );

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
module tb_alu_issue_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_rs, cmd_rt, cmd_rd;
  logic        cmd_imm_en;
  logic [15:0] cmd_imm;
  logic [31:0] alu_a, alu_b, alu_c;
  logic [2:0]  alu_op;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Stand-in for the external combinational alu.
  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  assign alu_c = alu_f(alu_op, alu_a, alu_b);

  alu_issue_unit dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
    .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Behavioural model: architectural rf plus one pending command with a due cycle.
  logic [31:0] rf_m [32];
  bit          pend;
  int          cyc, due;
  logic [4:0]  p_rd;
  logic [31:0] p_data;
  logic [31:0] m_a, m_b;
  logic [2:0]  m_op;
  bit          m_wb_v;
  logic [4:0]  m_wb_rd;
  logic [31:0] m_wb_data;
  logic [4:0]  sweep = 0;
  int          wb_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) rf_m[i] = '0;
    pend = 0; cyc = 0; due = 0;
    m_a = '0; m_b = '0; m_op = '0; m_wb_v = 0;
  endtask

  task automatic compare();
    chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, !pend});
    chk("wb_valid", {31'd0, wb_valid}, {31'd0, m_wb_v});
    if (m_wb_v) begin
      chk("wb_rd", {27'd0, wb_rd}, {27'd0, m_wb_rd});
      chk("wb_data", wb_data, m_wb_data);
    end
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_op", {29'd0, alu_op}, {29'd0, m_op});
    chk("dbg_data", dbg_data, rf_m[dbg_addr]);
  endtask

  // One clock: model observes the same edge as the DUT, compare on the falling edge.
  task automatic tick();
    dbg_addr = sweep;
    sweep    = sweep + 5'd7;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      cyc++;
      m_wb_v = 0;
      if (pend && cyc == due) begin
        if (p_rd != 0) rf_m[p_rd] = p_data;
        m_wb_v = 1; m_wb_rd = p_rd; m_wb_data = p_data; pend = 0;
      end else if (!pend && cmd_valid) begin
        m_a  = rf_m[cmd_rs];
        m_b  = cmd_imm_en ? {16'd0, cmd_imm} : rf_m[cmd_rt];
        m_op = cmd_op;
        p_data = alu_f(cmd_op, m_a, m_b);
        p_rd = cmd_rd; due = cyc + 2; pend = 1;
      end
    end
    @(negedge clk);
    compare();
    if (wb_valid) wb_cnt++;
  endtask

  task automatic set_cmd(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic ie, input logic [15:0] imm);
    cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd; cmd_imm_en = ie; cmd_imm = imm;
  endtask

  task automatic issue(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic ie, input logic [15:0] imm);
    set_cmd(op, rs, rt, rd, ie, imm);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic peek(input string name, input logic [4:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    chk(name, dbg_data, exp);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; dbg_addr = '0; wb_cnt = 0;
    set_cmd(3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 16'd0);
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("reset_ready", {31'd0, cmd_ready}, 32'd1);
    chk("reset_alu_a", alu_a, 32'd0);
    chk("reset_wb_valid", {31'd0, wb_valid}, 32'd0);

    // 1. immediate chain
    issue(3'd0, 5'd0, 5'd0, 5'd1, 1'b1, 16'd5);
    issue(3'd0, 5'd1, 5'd0, 5'd2, 1'b1, 16'd63);
    chk("t1_wb_data", wb_data, 32'd68);
    chk("t1_wb_rd", {27'd0, wb_rd}, 32'd2);
    peek("t1_rf2", 5'd2, 32'd68);

    // 2. register-form SUB
    issue(3'd0, 5'd0, 5'd0, 5'd3, 1'b1, 16'd79);
    issue(3'd0, 5'd0, 5'd0, 5'd4, 1'b1, 16'd63);
    issue(3'd1, 5'd3, 5'd4, 5'd5, 1'b0, 16'hBEEF);
    chk("t2_wb_data", wb_data, 32'd16);
    peek("t2_rf5", 5'd5, 32'd16);

    // extra op coverage; immediate must zero-extend
    issue(3'd0, 5'd0, 5'd0, 5'd7, 1'b1, 16'hFFFF);
    peek("imm_zext", 5'd7, 32'h0000FFFF);
    issue(3'd4, 5'd7, 5'd3, 5'd8, 1'b0, 16'd0);
    peek("xor_rf8", 5'd8, 32'h0000FFB0);
    issue(3'd1, 5'd4, 5'd3, 5'd10, 1'b0, 16'd0);
    issue(3'd5, 5'd10, 5'd4, 5'd11, 1'b0, 16'd0);
    peek("slt_rf11", 5'd11, 32'd1);

    // 3. back-to-back with rs==rd chaining
    set_cmd(3'd0, 5'd6, 5'd0, 5'd6, 1'b1, 16'd1);
    cmd_valid = 1'b1;
    wb_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("t3_ready_pat", {31'd0, cmd_ready}, (i % 3 == 2) ? 32'd1 : 32'd0);
    end
    cmd_valid = 1'b0;
    chk("t3_wb_count", wb_cnt, 32'd3);
    peek("t3_rf6", 5'd6, 32'd3);

    // 4. rd==0 still reports a write-back
    issue(3'd0, 5'd2, 5'd0, 5'd0, 1'b1, 16'd9);
    chk("t4_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("t4_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("t4_wb_data", wb_data, 32'd77);
    peek("t4_rf0", 5'd0, 32'd0);

    // 6. valid pulsed while busy is ignored
    wb_cnt = 0;
    set_cmd(3'd0, 5'd0, 5'd0, 5'd12, 1'b1, 16'd3);
    cmd_valid = 1'b1;
    tick();
    set_cmd(3'd0, 5'd0, 5'd0, 5'd9, 1'b1, 16'd77);
    tick();
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    chk("t6_wb_count", wb_cnt, 32'd1);
    peek("t6_rf9", 5'd9, 32'd0);
    peek("t6_rf12", 5'd12, 32'd3);

    // 5. reset during EXEC
    set_cmd(3'd0, 5'd2, 5'd0, 5'd13, 1'b1, 16'd1);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("t5_alu_a", alu_a, 32'd0);
    for (int i = 0; i < 32; i++) peek("t5_rf_clear", 5'(i), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("t5_ready", {31'd0, cmd_ready}, 32'd1);
    chk("t5_alu_b", alu_b, 32'd0);
    wb_cnt = 0;
    tick(); tick(); tick();
    chk("t5_no_wb", wb_cnt, 32'd0);

    issue(3'd3, 5'd0, 5'd0, 5'd14, 1'b1, 16'h00A5);
    peek("post_reset_rf14", 5'd14, 32'h000000A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
